// File: rtl/pc_delay_unit.sv
// Program-counter unit with configurable branch delay slots,
// stall, exception redirect and delay-slot tagging.
module pc_delay_unit #(
  parameter int          WIDTH        = 32,
  parameter logic [31:0] RESET_VECTOR = 32'hBFC00000,
  parameter logic [31:0] EXC_VECTOR   = 32'hBFC00380,
  parameter int          DELAY_SLOTS  = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clk_enable,
  input  logic             stall,
  input  logic             branch_valid,
  input  logic [WIDTH-1:0] branch_target,
  input  logic             exc_valid,
  output logic [WIDTH-1:0] pc,
  output logic [WIDTH-1:0] pc_plus4,
  output logic             in_delay_slot,
  output logic             branch_dropped,
  output logic             misaligned
);

  generate
    if (DELAY_SLOTS < 0 || DELAY_SLOTS > 3) begin : g_bad_slots
      $error("pc_delay_unit: DELAY_SLOTS must be 0..3");
    end
    if (WIDTH < 8) begin : g_bad_width
      $error("pc_delay_unit: WIDTH must be >= 8");
    end
  endgenerate

  localparam logic [WIDTH-1:0] RST_PC = WIDTH'(RESET_VECTOR);
  localparam logic [WIDTH-1:0] EXC_PC = WIDTH'(EXC_VECTOR);
  localparam logic [1:0] REM_INIT =
    (DELAY_SLOTS > 0) ? 2'(DELAY_SLOTS - 1) : 2'd0;

  logic             pending_q, pending_d;
  logic [1:0]       remaining_q, remaining_d;
  logic [WIDTH-1:0] target_q, target_d;
  logic [WIDTH-1:0] pc_d;
  logic             dropped_d;

  assign pc_plus4      = pc + WIDTH'(4);
  assign misaligned    = |pc[1:0];
  assign in_delay_slot = pending_q;

  always_comb begin
    pc_d        = pc;
    pending_d   = pending_q;
    remaining_d = remaining_q;
    target_d    = target_q;
    dropped_d   = 1'b0;
    if (!clk_enable) begin
      dropped_d = 1'b0;
    end else if (exc_valid) begin
      pc_d        = EXC_PC;
      pending_d   = 1'b0;
      remaining_d = 2'd0;
    end else if (stall) begin
      dropped_d = 1'b0;
    end else if (pending_q) begin
      // a branch sitting in a delay slot cannot redirect again
      dropped_d = branch_valid;
      if (remaining_q == 2'd0) begin
        pc_d      = target_q;
        pending_d = 1'b0;
      end else begin
        pc_d        = pc_plus4;
        remaining_d = remaining_q - 2'd1;
      end
    end else if (branch_valid) begin
      if (DELAY_SLOTS == 0) begin
        pc_d = branch_target;
      end else begin
        pc_d        = pc_plus4;
        pending_d   = 1'b1;
        remaining_d = REM_INIT;
        target_d    = branch_target;
      end
    end else begin
      pc_d = pc_plus4;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pc             <= RST_PC;
      pending_q      <= 1'b0;
      remaining_q    <= 2'd0;
      target_q       <= '0;
      branch_dropped <= 1'b0;
    end else begin
      pc             <= pc_d;
      pending_q      <= pending_d;
      remaining_q    <= remaining_d;
      target_q       <= target_d;
      branch_dropped <= dropped_d;
    end
  end

endmodule

// File: tb/tb_pc_delay_unit.sv
// Directed bench for pc_delay_unit with DELAY_SLOTS = 1, 2 and 0.
// Inputs change and outputs are sampled 1 time unit after each rising edge.
module tb_pc_delay_unit;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        clk_enable = 1'b1;
  logic        stall = 1'b0;
  logic        branch_valid = 1'b0;
  logic [31:0] branch_target = '0;
  logic        exc_valid = 1'b0;

  logic [31:0] pc1, pp1, pc2, pp2, pc0, pp0;
  logic        ds1, bd1, mis1, ds2, bd2, mis2, ds0, bd0, mis0;

  int n_chk = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  pc_delay_unit #(.DELAY_SLOTS(1)) u1 (
    .clk(clk), .reset(reset), .clk_enable(clk_enable), .stall(stall),
    .branch_valid(branch_valid), .branch_target(branch_target),
    .exc_valid(exc_valid), .pc(pc1), .pc_plus4(pp1),
    .in_delay_slot(ds1), .branch_dropped(bd1), .misaligned(mis1));

  pc_delay_unit #(.DELAY_SLOTS(2)) u2 (
    .clk(clk), .reset(reset), .clk_enable(clk_enable), .stall(stall),
    .branch_valid(branch_valid), .branch_target(branch_target),
    .exc_valid(exc_valid), .pc(pc2), .pc_plus4(pp2),
    .in_delay_slot(ds2), .branch_dropped(bd2), .misaligned(mis2));

  pc_delay_unit #(.DELAY_SLOTS(0)) u0 (
    .clk(clk), .reset(reset), .clk_enable(clk_enable), .stall(stall),
    .branch_valid(branch_valid), .branch_target(branch_target),
    .exc_valid(exc_valid), .pc(pc0), .pc_plus4(pp0),
    .in_delay_slot(ds0), .branch_dropped(bd0), .misaligned(mis0));

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    clk_enable = 1'b1; stall = 1'b0; exc_valid = 1'b0;
    branch_valid = 1'b0; branch_target = '0;
  endtask

  task automatic do_reset();
    idle_inputs();
    reset = 1'b1;
    step();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    logic [31:0] exp_pc;
    do_reset();
    n_chk++; if (pc1 !== 32'hBFC00000) begin n_fail++; $display("FAIL reset_pc: got %h exp %h", pc1, 32'hBFC00000); end
    n_chk++; if (pp1 !== 32'hBFC00004) begin n_fail++; $display("FAIL reset_pc_plus4: got %h exp %h", pp1, 32'hBFC00004); end
    n_chk++; if ({ds1, bd1, mis1} !== 3'b000) begin n_fail++; $display("FAIL reset_flags: got %b exp 000", {ds1, bd1, mis1}); end
    exp_pc = 32'hBFC00000;
    for (int i = 0; i < 3; i++) begin
      step();
      exp_pc = exp_pc + 32'd4;
      n_chk++; if (pc1 !== exp_pc || ds1 !== 1'b0) begin n_fail++; $display("FAIL seq_advance[%0d]: got %h/%b exp %h/0", i, pc1, ds1, exp_pc); end
    end
  endtask

  // reset, two advances, then issue the branch at BFC00008
  task automatic branch_at_8(input logic [31:0] tgt);
    do_reset();
    step(); step();
    branch_valid = 1'b1; branch_target = tgt;
    step();
    branch_valid = 1'b0;
  endtask

  task automatic test_branch();
    branch_at_8(32'hBFC00100);
    n_chk++; if (pc1 !== 32'hBFC0000C || ds1 !== 1'b1) begin n_fail++; $display("FAIL br_slot: got %h/%b exp bfc0000c/1", pc1, ds1); end
    step();
    n_chk++; if (pc1 !== 32'hBFC00100 || ds1 !== 1'b0) begin n_fail++; $display("FAIL br_target: got %h/%b exp bfc00100/0", pc1, ds1); end
    step();
    n_chk++; if (pc1 !== 32'hBFC00104) begin n_fail++; $display("FAIL br_after: got %h exp bfc00104", pc1); end
  endtask

  task automatic test_stall();
    branch_at_8(32'hBFC00100);
    stall = 1'b1;
    branch_valid = 1'b1; branch_target = 32'hBFC00200;
    for (int i = 0; i < 2; i++) begin
      step();
      n_chk++; if (pc1 !== 32'hBFC0000C || ds1 !== 1'b1 || bd1 !== 1'b0) begin n_fail++; $display("FAIL stall_hold[%0d]: got %h/%b/%b exp bfc0000c/1/0", i, pc1, ds1, bd1); end
    end
    stall = 1'b0; branch_valid = 1'b0;
    step();
    n_chk++; if (pc1 !== 32'hBFC00100 || ds1 !== 1'b0) begin n_fail++; $display("FAIL stall_release: got %h/%b exp bfc00100/0", pc1, ds1); end
  endtask

  task automatic test_clk_enable();
    branch_at_8(32'hBFC00100);
    clk_enable = 1'b0;
    branch_valid = 1'b1; branch_target = 32'hBFC00200;
    for (int i = 0; i < 3; i++) begin
      step();
      n_chk++; if (pc1 !== 32'hBFC0000C || ds1 !== 1'b1 || bd1 !== 1'b0) begin n_fail++; $display("FAIL en_hold[%0d]: got %h/%b/%b exp bfc0000c/1/0", i, pc1, ds1, bd1); end
    end
    clk_enable = 1'b1; branch_valid = 1'b0;
    step();
    n_chk++; if (pc1 !== 32'hBFC00100) begin n_fail++; $display("FAIL en_release: got %h exp bfc00100", pc1); end
  endtask

  task automatic test_dropped();
    branch_at_8(32'hBFC00100);
    branch_valid = 1'b1; branch_target = 32'hBFC00200;
    step();
    branch_valid = 1'b0;
    n_chk++; if (pc1 !== 32'hBFC00100 || bd1 !== 1'b1 || ds1 !== 1'b0) begin n_fail++; $display("FAIL drop_pulse: got %h/%b/%b exp bfc00100/1/0", pc1, bd1, ds1); end
    step();
    n_chk++; if (pc1 !== 32'hBFC00104 || bd1 !== 1'b0) begin n_fail++; $display("FAIL drop_clear: got %h/%b exp bfc00104/0", pc1, bd1); end
  endtask

  task automatic test_exception();
    branch_at_8(32'hBFC00100);
    exc_valid = 1'b1; stall = 1'b1;
    step();
    exc_valid = 1'b0; stall = 1'b0;
    n_chk++; if (pc1 !== 32'hBFC00380 || ds1 !== 1'b0) begin n_fail++; $display("FAIL exc_stall: got %h/%b exp bfc00380/0", pc1, ds1); end
    step();
    n_chk++; if (pc1 !== 32'hBFC00384) begin n_fail++; $display("FAIL exc_next: got %h exp bfc00384", pc1); end
    step();
    n_chk++; if (pc1 !== 32'hBFC00388) begin n_fail++; $display("FAIL exc_no_target: got %h exp bfc00388", pc1); end
    // exception with a branch presented in the same cycle
    branch_at_8(32'hBFC00100);
    exc_valid = 1'b1; branch_valid = 1'b1; branch_target = 32'hBFC00200;
    step();
    exc_valid = 1'b0; branch_valid = 1'b0;
    n_chk++; if (pc1 !== 32'hBFC00380 || ds1 !== 1'b0 || bd1 !== 1'b0) begin n_fail++; $display("FAIL exc_branch: got %h/%b/%b exp bfc00380/0/0", pc1, ds1, bd1); end
    step();
    n_chk++; if (pc1 !== 32'hBFC00384 || ds1 !== 1'b0) begin n_fail++; $display("FAIL exc_branch_next: got %h/%b exp bfc00384/0", pc1, ds1); end
  endtask

  task automatic test_d2();
    do_reset();
    branch_valid = 1'b1; branch_target = 32'h00000100;
    step();
    branch_valid = 1'b0;
    n_chk++; if (pc2 !== 32'hBFC00004 || ds2 !== 1'b1) begin n_fail++; $display("FAIL d2_slot0: got %h/%b exp bfc00004/1", pc2, ds2); end
    step();
    n_chk++; if (pc2 !== 32'hBFC00008 || ds2 !== 1'b1) begin n_fail++; $display("FAIL d2_slot1: got %h/%b exp bfc00008/1", pc2, ds2); end
    step();
    n_chk++; if (pc2 !== 32'h00000100 || ds2 !== 1'b0) begin n_fail++; $display("FAIL d2_tgt1: got %h/%b exp 00000100/0", pc2, ds2); end
    branch_valid = 1'b1; branch_target = 32'h00000400;
    step();
    branch_valid = 1'b0;
    n_chk++; if (pc2 !== 32'h00000104 || ds2 !== 1'b1) begin n_fail++; $display("FAIL d2_104: got %h/%b exp 00000104/1", pc2, ds2); end
    step();
    n_chk++; if (pc2 !== 32'h00000108 || ds2 !== 1'b1) begin n_fail++; $display("FAIL d2_108: got %h/%b exp 00000108/1", pc2, ds2); end
    step();
    n_chk++; if (pc2 !== 32'h00000400 || ds2 !== 1'b0) begin n_fail++; $display("FAIL d2_400: got %h/%b exp 00000400/0", pc2, ds2); end
  endtask

  task automatic test_d0();
    do_reset();
    branch_valid = 1'b1; branch_target = 32'h00000100;
    step();
    n_chk++; if (pc0 !== 32'h00000100 || ds0 !== 1'b0) begin n_fail++; $display("FAIL d0_100: got %h/%b exp 00000100/0", pc0, ds0); end
    branch_target = 32'h00000400;
    step();
    n_chk++; if (pc0 !== 32'h00000400 || ds0 !== 1'b0 || bd0 !== 1'b0) begin n_fail++; $display("FAIL d0_400: got %h/%b/%b exp 00000400/0/0", pc0, ds0, bd0); end
    branch_target = 32'hFFFFFFFC;
    step();
    branch_valid = 1'b0;
    n_chk++; if (pc0 !== 32'hFFFFFFFC || pp0 !== 32'h00000000) begin n_fail++; $display("FAIL d0_top: got %h/%h exp fffffffc/00000000", pc0, pp0); end
    step();
    n_chk++; if (pc0 !== 32'h00000000 || mis0 !== 1'b0) begin n_fail++; $display("FAIL wrap: got %h/%b exp 00000000/0", pc0, mis0); end
    branch_valid = 1'b1; branch_target = 32'h00000402;
    step();
    branch_valid = 1'b0;
    n_chk++; if (pc0 !== 32'h00000402 || mis0 !== 1'b1) begin n_fail++; $display("FAIL misaligned: got %h/%b exp 00000402/1", pc0, mis0); end
  endtask

  task automatic test_reset_pending();
    do_reset();
    branch_valid = 1'b1; branch_target = 32'h00000100;
    step();
    branch_valid = 1'b0;
    n_chk++; if (pc1 !== 32'hBFC00004 || ds1 !== 1'b1) begin n_fail++; $display("FAIL rp_slot: got %h/%b exp bfc00004/1", pc1, ds1); end
    reset = 1'b1; clk_enable = 1'b0;
    step();
    reset = 1'b0; clk_enable = 1'b1;
    n_chk++; if (pc1 !== 32'hBFC00000 || ds1 !== 1'b0) begin n_fail++; $display("FAIL rp_reset: got %h/%b exp bfc00000/0", pc1, ds1); end
    step();
    n_chk++; if (pc1 !== 32'hBFC00004 || ds1 !== 1'b0) begin n_fail++; $display("FAIL rp_cleared: got %h/%b exp bfc00004/0", pc1, ds1); end
  endtask

  initial begin
    test_reset();
    test_branch();
    test_stall();
    test_clk_enable();
    test_dropped();
    test_exception();
    test_d2();
    test_d0();
    test_reset_pending();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
